uio_bus_arbiter: RTL
====================

# uio_bus_arbiter

Shares the 8-bit bidirectional uio pad bus between up to four on-chip requesters, for example the FSM core, a debug/config shifter and a BIST pattern source, inside the user project wrapper. It uses a req/gnt handshake with round-robin arbitration and a forced all-inputs turnaround window on every ownership change, so no two masters ever drive the pads in adjacent cycles. Pad outputs are registered. The pad-facing side connects directly to uio_out/uio_oe/uio_in of the wrapper.

## Interface
- N_REQ, default 2: number of requesters, legal 2..4
- TURN_CYCLES, default 1: cycles with uio_oe forced to 0 between owners, legal 1..7
- MAX_HOLD, default 16: maximum OWN cycles before forced preemption (only with timeout enabled), legal 2..255
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req  in  N_REQ  level request per requester; held high for as long as bus access is wanted
- gnt  out  N_REQ  one-hot grant, registered
- m_out  in  N_REQ*8  per-requester output data, slice k = bits [8k+7:8k]
- m_oe  in  N_REQ*8  per-requester output enables, same slicing
- uio_out  out  8  registered pad data
- uio_oe  out  8  registered pad enables, 1 = drive
- uio_in  in  8  pad input
- m_in  out  8  combinational copy of uio_in, broadcast to all requesters
- owner  out  2  index of the current or pending owner, registered
- busy  out  1  high in TURN or OWN

## Operation
- States: IDLE, TURN, OWN.
- IDLE: gnt=0, uio_oe=0, uio_out=0.
  - Any req high -> latch round-robin winner into owner -> TURN.
- Round-robin: search starts at last_owner+1 mod N_REQ and takes the first req set. last_owner resets to N_REQ-1, so requester 0 wins the first contention.
- TURN: gnt=0, uio_oe=0.
  - turn_cnt counts 0..TURN_CYCLES-1. On the last count:
    - req[owner] still high -> OWN, and gnt[owner] is set.
    - req[owner] dropped -> IDLE with no grant.
  - Requests arriving during TURN wait; the winner is not re-evaluated.
- OWN: gnt[owner]=1; each cycle uio_out<=m_out[owner], uio_oe<=m_oe[owner].
  - req[owner] low -> gnt clears and uio_out/uio_oe load 0 on the same edge. last_owner<=owner. Next state is TURN with a new winner if any other req is high, else IDLE.
- Simultaneous events: owner release and another requester's rise in the same cycle go directly to TURN for that requester. A requester never wins back-to-back over a pending other requester.
- Owner slices outside N_REQ are unused; out-of-range owner values are unreachable.
- rst in any state: IDLE, gnt=0, uio_out=0, uio_oe=0, owner=0, busy=0, counters=0, last_owner=N_REQ-1. An in-flight grant is dropped without a turnaround.

## Timing
- req[k] rises in cycle 0, bus IDLE, no contention:
  - Cycle 1: TURN, busy=1.
  - Cycle 1+TURN_CYCLES: gnt[k]=1.
  - m_out presented in grant cycle g appears on uio_out/uio_oe in cycle g+1.
- Release: req[k] low in cycle t -> gnt[k]=0 and uio_oe=0 in cycle t+1.
- Next owner's gnt earliest at t+1+TURN_CYCLES. Its pad drive starts one cycle after that.
- Guaranteed pad-idle gap between owners: at least TURN_CYCLES+1 cycles of uio_oe=0.
- m_in has zero latency (wire).

## Configuration
- UIO_ARB_TIMEOUT_EN defined:
  - An 8-bit hold_cnt clears on OWN entry and increments each OWN cycle, saturating at MAX_HOLD.
  - When hold_cnt==MAX_HOLD and another req is high, ownership is preempted exactly like a release: gnt clears, then TURN to the next round-robin winner.
  - If no other req is pending, the owner keeps the bus and hold_cnt stays saturated.
  - The preempted requester must re-request by keeping req high; it is rescheduled in round-robin order.
- Undefined: no hold_cnt, no preemption; the owner holds the bus until it drops req.

## Structure
- Package uio_arb_pkg holds:
  - the state enum (IDLE, TURN, OWN)
  - UIO_W=8
  - OWNER_W=2
  - the hold counter width
- Sub-module uio_rr_pick: combinational round-robin selector with inputs req and last_owner, outputs valid and idx. It is instantiated once in the arbiter.

## Test plan
- N_REQ=2, TURN_CYCLES=1: req[0] rises cycle 0 -> gnt=01 cycle 2. m_out[0]=8'hA5, m_oe[0]=8'hFF in cycle 2 -> uio_out=A5, uio_oe=FF in cycle 3.
- Both req high from cycle 0 -> requester 0 owns. Drop req[0] at cycle 10 -> cycle 11 gnt=00 and uio_oe=00. Cycle 12 gnt=10. Pads show no overlapping drive.
- req[1] withdrawn during its TURN -> state returns to IDLE, gnt never asserts, uio_oe stays 00.
- rst pulsed while requester 1 owns with uio_oe=FF -> next cycle all outputs 0 and state IDLE. Re-contention of both requesters grants requester 0.
- UIO_ARB_TIMEOUT_EN, MAX_HOLD=4, both req held high -> grants alternate 01/10. Each OWN lasts 5 cycles, separated by TURN_CYCLES+1 cycles of uio_oe=00. Without the macro, requester 0 holds indefinitely.
- N_REQ=3, requesters 1 and 2 pending when requester 0 releases -> requester 1 granted, then requester 2, then 0 (round-robin order).

Source files
------------

// File: rtl/uio_arb_pkg.sv
// uio_arb_pkg
// Shared types and constants for the uio pad bus arbiter.
//   - arb_state_e : arbiter state encoding (IDLE, TURN, OWN)
//   - UIO_W       : pad bus width
//   - OWNER_W     : width of an owner index (up to four requesters)
//   - HOLD_W      : width of the ownership hold counter
//   - TURN_W      : width of the turnaround counter (up to 7 cycles)
//   - MAX_REQ     : largest supported requester count
//   - rr_step     : round-robin successor of an index, wrapping at n_req
package uio_arb_pkg;

    localparam int UIO_W   = 8;
    localparam int OWNER_W = 2;
    localparam int HOLD_W  = 8;
    localparam int TURN_W  = 3;
    localparam int MAX_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } arb_state_e;

    // Next index in round-robin order, wrapping from n_req-1 back to 0.
    function automatic logic [OWNER_W-1:0] rr_step(input logic [OWNER_W-1:0] idx,
                                                   input int n_req);
        logic [OWNER_W-1:0] nxt;
        if (int'(idx) >= (n_req - 32'sd1)) begin
            nxt = '0;
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/uio_rr_pick.sv
// uio_rr_pick
// Combinational round-robin selector. The search starts at last_owner+1
// (mod N_REQ) and returns the first requester whose req bit is set.
// Because last_owner itself is visited last, a requester that is still
// asking never beats another pending requester right after its own turn.
// Ports:
//   req        in  N_REQ    request vector
//   last_owner in  OWNER_W  index the search starts after
//   valid      out 1        at least one request is set
//   idx        out OWNER_W  winning requester index (0 when !valid)
module uio_rr_pick
    import uio_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [OWNER_W-1:0] last_owner,
    output logic               valid,
    output logic [OWNER_W-1:0] idx
);

    logic [MAX_REQ-1:0] req_pad_s;
    logic [OWNER_W-1:0] cand_s;

    // Walk the candidates in rotating priority order and keep the first hit.
    always_comb begin
        req_pad_s              = '0;
        req_pad_s[N_REQ-1:0]   = req;
        valid                  = 1'b0;
        idx                    = '0;
        cand_s                 = rr_step(last_owner, N_REQ);
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid && req_pad_s[cand_s]) begin
                valid = 1'b1;
                idx   = cand_s;
            end else begin
                valid = valid;
            end
            cand_s = rr_step(cand_s, N_REQ);
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter
// Shares the 8-bit bidirectional uio pad bus between N_REQ on-chip
// requesters with a level req / registered one-hot gnt handshake and
// round-robin arbitration. Every change of ownership passes through a TURN
// window of TURN_CYCLES cycles with all pad enables low, so two masters
// never drive the pads in adjacent cycles. Pad outputs are registered.
//
// Optional feature macro: UIO_ARB_TIMEOUT_EN
//   When defined, an owner that has held the bus for MAX_HOLD cycles is
//   preempted if another requester is waiting. When undefined, the owner
//   keeps the bus until it drops req.
//
// Parameters: N_REQ (2..4), TURN_CYCLES (1..7), MAX_HOLD (2..255)
// Ports:
//   clk      in  1            rising-edge clock
//   rst      in  1            synchronous active-high reset
//   req      in  N_REQ        level request per requester
//   gnt      out N_REQ        one-hot grant, registered
//   m_out    in  N_REQ*8      per-requester pad data, slice k = [8k+7:8k]
//   m_oe     in  N_REQ*8      per-requester pad enables, same slicing
//   uio_out  out 8            registered pad data
//   uio_oe   out 8            registered pad enables (1 = drive)
//   uio_in   in  8            pad input
//   m_in     out 8            uio_in broadcast to all requesters (wire)
//   owner    out 2            current or pending owner, registered
//   busy     out 1            high in TURN or OWN, registered
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    output logic [N_REQ-1:0]       gnt,
    input  logic [N_REQ*UIO_W-1:0] m_out,
    input  logic [N_REQ*UIO_W-1:0] m_oe,
    output logic [UIO_W-1:0]       uio_out,
    output logic [UIO_W-1:0]       uio_oe,
    input  logic [UIO_W-1:0]       uio_in,
    output logic [UIO_W-1:0]       m_in,
    output logic [OWNER_W-1:0]     owner,
    output logic                   busy
);

    if ((N_REQ < 2) || (N_REQ > MAX_REQ)) begin : g_bad_n_req
        $error("uio_bus_arbiter: N_REQ must be 2..4");
    end
    if ((TURN_CYCLES < 1) || (TURN_CYCLES > 7)) begin : g_bad_turn
        $error("uio_bus_arbiter: TURN_CYCLES must be 1..7");
    end
    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_hold
        $error("uio_bus_arbiter: MAX_HOLD must be 2..255");
    end

    localparam logic [TURN_W-1:0]  TURN_LAST  = TURN_W'(TURN_CYCLES - 1);
    localparam logic [OWNER_W-1:0] LAST_RESET = OWNER_W'(N_REQ - 1);

    arb_state_e         state_r, state_n;
    logic [OWNER_W-1:0] owner_r, owner_n;
    logic [OWNER_W-1:0] last_owner_r, last_owner_n;
    logic [TURN_W-1:0]  turn_cnt_r, turn_cnt_n;
    logic [N_REQ-1:0]   gnt_r, gnt_n;
    logic [UIO_W-1:0]   uio_out_r, uio_out_n;
    logic [UIO_W-1:0]   uio_oe_r, uio_oe_n;
    logic               busy_r, busy_n;

    logic [OWNER_W-1:0] pick_base_s;
    logic               pick_valid_s;
    logic [OWNER_W-1:0] pick_idx_s;
    logic               other_pending_s;
    logic               req_own_s;
    logic [UIO_W-1:0]   own_out_s;
    logic [UIO_W-1:0]   own_oe_s;
    logic [N_REQ-1:0]   own_hot_s;
    logic               preempt_s;
    logic               own_entry_s;

    // While a requester owns the bus the search rotates from it, so the
    // release edge can pick the successor before last_owner is updated.
    always_comb begin
        if (state_r == ST_OWN) begin
            pick_base_s = owner_r;
        end else begin
            pick_base_s = last_owner_r;
        end
    end

    uio_rr_pick #(
        .N_REQ      (N_REQ)
    ) u_rr_pick (
        .req        (req),
        .last_owner (pick_base_s),
        .valid      (pick_valid_s),
        .idx        (pick_idx_s)
    );

    // The picker only returns the owner itself when nobody else is asking.
    always_comb begin
        other_pending_s = pick_valid_s && (pick_idx_s != owner_r);
    end

    // Decode the owner index into its request bit, data slices and one-hot.
    always_comb begin
        req_own_s = 1'b0;
        own_out_s = '0;
        own_oe_s  = '0;
        own_hot_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_r == OWNER_W'(k)) begin
                req_own_s    = req[k];
                own_out_s    = m_out[k*UIO_W +: UIO_W];
                own_oe_s     = m_oe[k*UIO_W +: UIO_W];
                own_hot_s[k] = 1'b1;
            end else begin
                own_hot_s[k] = 1'b0;
            end
        end
    end

    // Detect the TURN -> OWN hand-over edge (restarts the hold counter).
    always_comb begin
        own_entry_s = (state_r == ST_TURN) && (turn_cnt_r == TURN_LAST) && req_own_s;
    end

`ifdef UIO_ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt_r;

    // Count OWN cycles, saturating so a lone owner keeps the bus indefinitely.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= '0;
        end else if (own_entry_s) begin
            hold_cnt_r <= '0;
        end else if ((state_r == ST_OWN) && (hold_cnt_r != HOLD_MAX)) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    // Preempt only when the hold limit is reached and someone else waits.
    always_comb begin
        preempt_s = (hold_cnt_r == HOLD_MAX) && other_pending_s;
    end
`else
    // Without the timeout feature the owner is never preempted.
    always_comb begin
        preempt_s = 1'b0;
    end
`endif

    // Next-state and next-output logic for the IDLE / TURN / OWN machine.
    always_comb begin
        state_n      = state_r;
        owner_n      = owner_r;
        last_owner_n = last_owner_r;
        turn_cnt_n   = turn_cnt_r;
        gnt_n        = '0;
        uio_out_n    = '0;
        uio_oe_n     = '0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    owner_n    = pick_idx_s;
                    turn_cnt_n = '0;
                    state_n    = ST_TURN;
                end else begin
                    state_n    = ST_IDLE;
                end
            end
            ST_TURN: begin
                // The winner is fixed for the whole window; late arrivals wait.
                if (turn_cnt_r == TURN_LAST) begin
                    turn_cnt_n = '0;
                    if (req_own_s) begin
                        state_n = ST_OWN;
                        gnt_n   = own_hot_s;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    turn_cnt_n = turn_cnt_r + 3'd1;
                end
            end
            ST_OWN: begin
                if (!req_own_s || preempt_s) begin
                    // Release or preemption: pads go quiet on this same edge.
                    last_owner_n = owner_r;
                    if (other_pending_s) begin
                        owner_n    = pick_idx_s;
                        turn_cnt_n = '0;
                        state_n    = ST_TURN;
                    end else begin
                        state_n    = ST_IDLE;
                    end
                end else begin
                    gnt_n     = own_hot_s;
                    uio_out_n = own_out_s;
                    uio_oe_n  = own_oe_s;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= '0;
            last_owner_r <= LAST_RESET;
            turn_cnt_r   <= '0;
            gnt_r        <= '0;
            uio_out_r    <= '0;
            uio_oe_r     <= '0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            owner_r      <= owner_n;
            last_owner_r <= last_owner_n;
            turn_cnt_r   <= turn_cnt_n;
            gnt_r        <= gnt_n;
            uio_out_r    <= uio_out_n;
            uio_oe_r     <= uio_oe_n;
            busy_r       <= busy_n;
        end
    end

    assign gnt     = gnt_r;
    assign uio_out = uio_out_r;
    assign uio_oe  = uio_oe_r;
    assign owner   = owner_r;
    assign busy    = busy_r;
    assign m_in    = uio_in;

endmodule
